// File: rtl/sram_pkg.sv
// Shared widths, requester IDs and FSM encoding for the character SRAM arbiter.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 10;
  localparam int unsigned SRAM_DATA_W = 8;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_VID  = 2'd0;
  localparam req_id_t REQ_CA   = 2'd1;
  localparam req_id_t REQ_UART = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Which of CA / UART wins the next contest between the two
  typedef enum logic {
    RR_CA   = 1'b0,
    RR_UART = 1'b1
  } rr_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: three request ports plus shared read data.
interface sram_arbiter_if
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;

  logic              ca_req;
  logic              ca_we;
  logic [ADDR_W-1:0] ca_addr;
  logic [DATA_W-1:0] ca_wdata;
  logic              ca_gnt;
  logic              ca_rvalid;

  logic              uart_req;
  logic              uart_we;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic              uart_gnt;
  logic              uart_rvalid;

  logic [DATA_W-1:0] rd_data;

  modport master (
    output vid_req, vid_addr,
    output ca_req, ca_we, ca_addr, ca_wdata,
    output uart_req, uart_we, uart_addr, uart_wdata,
    input  vid_gnt, vid_rvalid, ca_gnt, ca_rvalid, uart_gnt, uart_rvalid,
    input  rd_data
  );

  modport slave (
    input  vid_req, vid_addr,
    input  ca_req, ca_we, ca_addr, ca_wdata,
    input  uart_req, uart_we, uart_addr, uart_wdata,
    output vid_gnt, vid_rvalid, ca_gnt, ca_rvalid, uart_gnt, uart_rvalid,
    output rd_data
  );

endinterface

// File: rtl/sram_req_pick.sv
// Combinational chooser: video has fixed priority, CA/UART contests settled by rr.
module sram_req_pick
  import sram_pkg::*;
(
  input  logic    vid_req,
  input  logic    ca_req,
  input  logic    uart_req,
  input  rr_t     rr,
  output logic [2:0] gnt_c,
  output req_id_t    win_c
);

  // Priority pick; a lone CA or UART request wins regardless of rr
  always_comb begin
    gnt_c = '0;
    win_c = REQ_VID;
    if (vid_req) begin
      gnt_c[REQ_VID] = 1'b1;
      win_c          = REQ_VID;
    end else if (ca_req && (!uart_req || rr == RR_CA)) begin
      gnt_c[REQ_CA] = 1'b1;
      win_c         = REQ_CA;
    end else if (uart_req) begin
      gnt_c[REQ_UART] = 1'b1;
      win_c           = REQ_UART;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port character SRAM among video, CA engine and UART bridge.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned WR_CYCLES = 1,
  parameter int unsigned WR_CNT_W  = 1
)(
  input  logic              clk50_dup,
  input  logic              reset,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_write_enable,
  input  logic [DATA_W-1:0] sram_read_data
);

  state_t              state;
  rr_t                 rr;
  logic [WR_CNT_W-1:0] wr_cnt;
  logic                vld_s1;
  req_id_t             id_s1;
  logic [2:0]          rv_q;

  logic [2:0]          pick_c;
  req_id_t             win_c;
  logic [2:0]          grant_c;
  logic                any_grant_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic [DATA_W-1:0]   win_wdata_c;
  logic                win_we_c;

  sram_req_pick u_pick (
    .vid_req  (bus.vid_req),
    .ca_req   (bus.ca_req),
    .uart_req (bus.uart_req),
    .rr       (rr),
    .gnt_c    (pick_c),
    .win_c    (win_c)
  );

  // Grants only while idle and out of reset
  assign grant_c     = (state == ST_IDLE && !reset) ? pick_c : 3'b000;
  assign any_grant_c = |grant_c;

  assign bus.vid_gnt     = grant_c[REQ_VID];
  assign bus.ca_gnt      = grant_c[REQ_CA];
  assign bus.uart_gnt    = grant_c[REQ_UART];
  assign bus.vid_rvalid  = rv_q[REQ_VID];
  assign bus.ca_rvalid   = rv_q[REQ_CA];
  assign bus.uart_rvalid = rv_q[REQ_UART];
  assign bus.rd_data     = sram_read_data;

  // Route the winner's address / write payload; video never writes
  always_comb begin
    win_addr_c  = bus.vid_addr;
    win_wdata_c = '0;
    win_we_c    = 1'b0;
    case (win_c)
      REQ_CA: begin
        win_addr_c  = bus.ca_addr;
        win_wdata_c = bus.ca_wdata;
        win_we_c    = bus.ca_we;
      end
      REQ_UART: begin
        win_addr_c  = bus.uart_addr;
        win_wdata_c = bus.uart_wdata;
        win_we_c    = bus.uart_we;
      end
      default: ;
    endcase
  end

  // FSM, round-robin pointer, write counter, registered SRAM controls, read-valid pipe.
  // The final WE cycle is spent back in IDLE (counter at 0) so the next grant can
  // land in cycle N+WR_CYCLES while the write completes on that cycle's edge.
  always_ff @(posedge clk50_dup) begin
    if (reset) begin
      state             <= ST_IDLE;
      rr                <= RR_CA;
      wr_cnt            <= '0;
      sram_address      <= '0;
      sram_write_data   <= '0;
      sram_write_enable <= 1'b0;
      vld_s1            <= 1'b0;
      id_s1             <= REQ_VID;
      rv_q              <= '0;
    end else begin
      vld_s1 <= 1'b0;
      rv_q   <= '0;
      if (vld_s1) begin
        rv_q[id_s1] <= 1'b1;
      end

      if (grant_c[REQ_CA]) begin
        rr <= RR_UART;
      end else if (grant_c[REQ_UART]) begin
        rr <= RR_CA;
      end

      case (state)
        ST_IDLE: begin
          sram_write_enable <= 1'b0;
          if (any_grant_c) begin
            sram_address <= win_addr_c;
            if (win_we_c) begin
              sram_write_data   <= win_wdata_c;
              sram_write_enable <= 1'b1;
              wr_cnt            <= WR_CNT_W'(WR_CYCLES - 1);
              if (WR_CYCLES > 1) begin
                state <= ST_WRITE;
              end
            end else begin
              vld_s1 <= 1'b1;
              id_s1  <= win_c;
            end
          end
        end
        ST_WRITE: begin
          wr_cnt <= wr_cnt - WR_CNT_W'(1);
          if (wr_cnt == WR_CNT_W'(1)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural synchronous-read SRAM.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int unsigned ADDR_W = SRAM_ADDR_W;
  localparam int unsigned DATA_W = SRAM_DATA_W;

  logic              clk50_dup;
  logic              reset;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_write_data;
  logic              sram_write_enable;
  logic [DATA_W-1:0] sram_read_data;

  int n_vec;
  int n_err;

  logic [DATA_W-1:0] mem [0:1023];
  logic              preload;

  sram_arbiter_if bus ();

  sram_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .WR_CYCLES (3),
    .WR_CNT_W  (2)
  ) dut (
    .clk50_dup         (clk50_dup),
    .reset             (reset),
    .bus               (bus),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_write_enable (sram_write_enable),
    .sram_read_data    (sram_read_data)
  );

  initial clk50_dup = 1'b0;
  always #5 clk50_dup = ~clk50_dup;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Preloaded contents: pattern everywhere except 0x155 which holds 0xA5
  function automatic logic [31:0] init_val(input int i);
    return (i == 'h155) ? 32'h0000_00A5 : 32'(pat(i));
  endfunction

  // Synchronous-read SRAM; read returns the pre-write contents on a shared edge
  always @(posedge clk50_dup) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      mem[10'h155] <= 8'hA5;
    end else if (sram_write_enable) begin
      mem[sram_address] <= sram_write_data;
    end
    sram_read_data <= mem[sram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk50_dup);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    preload = 1'b1;
    bus.vid_req = 1'b0;  bus.vid_addr = '0;
    bus.ca_req = 1'b0;   bus.ca_we = 1'b0;   bus.ca_addr = '0;   bus.ca_wdata = '0;
    bus.uart_req = 1'b0; bus.uart_we = 1'b0; bus.uart_addr = '0; bus.uart_wdata = '0;

    // Reset state
    next_cycle();
    preload = 1'b0;
    next_cycle();
    @(negedge clk50_dup);
    chk("rst_we",     32'(sram_write_enable), 0);
    chk("rst_addr",   32'(sram_address), 0);
    chk("rst_wdata",  32'(sram_write_data), 0);
    chk("rst_rvalid", 32'({bus.vid_rvalid, bus.ca_rvalid, bus.uart_rvalid}), 0);
    chk("rst_gnt",    32'({bus.vid_gnt, bus.ca_gnt, bus.uart_gnt}), 0);
    next_cycle();
    reset = 1'b0;

    // Lone UART read of 0x155
    next_cycle();
    bus.uart_req = 1'b1; bus.uart_we = 1'b0; bus.uart_addr = 10'h155;
    @(negedge clk50_dup);
    chk("t1_uart_gnt", 32'(bus.uart_gnt), 1);
    chk("t1_other_gnt", 32'({bus.vid_gnt, bus.ca_gnt}), 0);
    next_cycle();
    bus.uart_req = 1'b0;
    @(negedge clk50_dup);
    chk("t1_addr", 32'(sram_address), 'h155);
    chk("t1_rvalid_early", 32'(bus.uart_rvalid), 0);
    next_cycle();
    @(negedge clk50_dup);
    chk("t1_rvalid", 32'(bus.uart_rvalid), 1);
    chk("t1_rd_data", 32'(bus.rd_data), 'hA5);
    chk("t1_other_rvalid", 32'({bus.vid_rvalid, bus.ca_rvalid}), 0);
    next_cycle();
    @(negedge clk50_dup);
    chk("t1_rvalid_drop", 32'(bus.uart_rvalid), 0);

    // Video beats UART, UART follows next cycle
    next_cycle();
    bus.vid_req = 1'b1; bus.vid_addr = 10'h020;
    bus.uart_req = 1'b1; bus.uart_addr = 10'h155;
    @(negedge clk50_dup);
    chk("t2_vid_gnt", 32'(bus.vid_gnt), 1);
    chk("t2_uart_wait", 32'(bus.uart_gnt), 0);
    next_cycle();
    bus.vid_req = 1'b0;
    @(negedge clk50_dup);
    chk("t2_uart_gnt", 32'(bus.uart_gnt), 1);
    chk("t2_vid_idle", 32'(bus.vid_gnt), 0);
    next_cycle();
    bus.uart_req = 1'b0;
    @(negedge clk50_dup);
    chk("t2_vid_rvalid", 32'({bus.vid_rvalid, bus.uart_rvalid}), 'b10);
    chk("t2_vid_data", 32'(bus.rd_data), init_val('h020));
    next_cycle();
    @(negedge clk50_dup);
    chk("t2_uart_rvalid", 32'({bus.vid_rvalid, bus.uart_rvalid}), 'b01);
    chk("t2_uart_data", 32'(bus.rd_data), 'hA5);

    // CA and UART contend for six cycles: strict alternation starting with CA
    bus.ca_we = 1'b0; bus.ca_addr = 10'h001;
    bus.uart_we = 1'b0; bus.uart_addr = 10'h002;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus.ca_req = (i < 6);
      bus.uart_req = (i < 6);
      @(negedge clk50_dup);
      chk($sformatf("t3_ca_gnt_%0d", i), 32'(bus.ca_gnt), 32'((i < 6) && (i % 2 == 0)));
      chk($sformatf("t3_uart_gnt_%0d", i), 32'(bus.uart_gnt), 32'((i < 6) && (i % 2 == 1)));
      chk($sformatf("t3_rvalid_%0d", i), 32'({bus.ca_rvalid, bus.uart_rvalid}),
          (i >= 2) ? (((i - 2) % 2 == 0) ? 32'b10 : 32'b01) : 32'b00);
      if (i >= 2)
        chk($sformatf("t3_data_%0d", i), 32'(bus.rd_data),
            ((i - 2) % 2 == 0) ? init_val(1) : init_val(2));
    end

    // CA write of 0x3C to 0x010 (3 WE cycles), then a held UART read of it
    next_cycle();
    bus.ca_req = 1'b1; bus.ca_we = 1'b1; bus.ca_addr = 10'h010; bus.ca_wdata = 8'h3C;
    @(negedge clk50_dup);
    chk("t4_ca_gnt", 32'(bus.ca_gnt), 1);
    chk("t4_we_pre", 32'(sram_write_enable), 0);
    next_cycle();
    bus.ca_req = 1'b0; bus.ca_we = 1'b0;
    bus.uart_req = 1'b1; bus.uart_we = 1'b0; bus.uart_addr = 10'h010;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk50_dup);
      chk($sformatf("t4_we_%0d", k), 32'(sram_write_enable), 1);
      chk($sformatf("t4_addr_%0d", k), 32'(sram_address), 'h010);
      chk($sformatf("t4_wdata_%0d", k), 32'(sram_write_data), 'h3C);
      chk($sformatf("t4_uart_gnt_%0d", k), 32'(bus.uart_gnt), 32'(k == 3));
      next_cycle();
    end
    bus.uart_req = 1'b0;
    @(negedge clk50_dup);
    chk("t4_we_off", 32'(sram_write_enable), 0);
    chk("t4_rd_addr", 32'(sram_address), 'h010);
    next_cycle();
    @(negedge clk50_dup);
    chk("t4_uart_rvalid", 32'(bus.uart_rvalid), 1);
    chk("t4_rd_data", 32'(bus.rd_data), 'h3C);

    // Reset in the second WE cycle of a write that follows a read
    next_cycle();
    bus.uart_req = 1'b1; bus.uart_addr = 10'h155;
    @(negedge clk50_dup);
    chk("t5_uart_gnt", 32'(bus.uart_gnt), 1);
    next_cycle();
    bus.uart_req = 1'b0;
    bus.ca_req = 1'b1; bus.ca_we = 1'b1; bus.ca_addr = 10'h020; bus.ca_wdata = 8'h77;
    @(negedge clk50_dup);
    chk("t5_ca_gnt", 32'(bus.ca_gnt), 1);
    next_cycle();
    bus.ca_req = 1'b0; bus.ca_we = 1'b0;
    @(negedge clk50_dup);
    chk("t5_we_1", 32'(sram_write_enable), 1);
    chk("t5_uart_rvalid", 32'(bus.uart_rvalid), 1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk50_dup);
    chk("t5_we_2", 32'(sram_write_enable), 1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk50_dup);
    chk("t5_we_clr", 32'(sram_write_enable), 0);
    chk("t5_addr_clr", 32'(sram_address), 0);
    chk("t5_wdata_clr", 32'(sram_write_data), 0);
    chk("t5_state", 32'(dut.state), 32'(ST_IDLE));
    chk("t5_rvalid_clr", 32'({bus.vid_rvalid, bus.ca_rvalid, bus.uart_rvalid}), 0);

    // Read in flight is squashed by reset; grants are held off while reset is high
    next_cycle();
    bus.uart_req = 1'b1; bus.uart_addr = 10'h155;
    @(negedge clk50_dup);
    chk("t5b_uart_gnt", 32'(bus.uart_gnt), 1);
    next_cycle();
    bus.uart_req = 1'b0;
    reset = 1'b1;
    bus.vid_req = 1'b1; bus.vid_addr = 10'h030;
    @(negedge clk50_dup);
    chk("t5b_gnt_in_reset", 32'(bus.vid_gnt), 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk50_dup);
    chk("t5b_vid_gnt", 32'(bus.vid_gnt), 1);
    chk("t5b_uart_squash", 32'(bus.uart_rvalid), 0);
    next_cycle();
    bus.vid_req = 1'b0;
    @(negedge clk50_dup);
    chk("t5b_rvalid_quiet", 32'({bus.vid_rvalid, bus.uart_rvalid}), 0);
    next_cycle();
    @(negedge clk50_dup);
    chk("t5b_vid_rvalid", 32'(bus.vid_rvalid), 1);
    chk("t5b_vid_data", 32'(bus.rd_data), init_val('h030));

    // Restore memory contents, then stream video reads over the whole array
    next_cycle();
    preload = 1'b1;
    next_cycle();
    preload = 1'b0;
    for (int i = 0; i < 1026; i++) begin
      next_cycle();
      bus.vid_req = (i < 1024);
      if (i < 1024) bus.vid_addr = 10'(i);
      @(negedge clk50_dup);
      chk($sformatf("t6_gnt_%0d", i), 32'(bus.vid_gnt), 32'(i < 1024));
      chk($sformatf("t6_rvalid_%0d", i), 32'(bus.vid_rvalid), 32'(i >= 2));
      if (i >= 2)
        chk($sformatf("t6_data_%0d", i - 2), 32'(bus.rd_data), init_val(i - 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
